int_sync_crossing_sink_n: RTL and testbench

Parametrised interrupt crossing sink for the receive side of an interrupt crossing. Accepts NUM_INT interrupt lines from the source domain and resynchronises them through a configurable flop chain (0 stages = sync passthrough). An optional glitch filter follows. Each channel then presents as either a level output or a sticky rising-edge pending bit with software clear. Sits between the interrupt source crossing and the PLIC/CLINT interrupt inputs.

---
 rtl/int_xing_pkg.sv | 18 +
 rtl/int_xing_chan.sv | 80 ++++++++
 rtl/int_sync_crossing_sink_n.sv | 47 ++++
 tb/tb_int_sync_crossing_sink_n.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/int_xing_pkg.sv
// Shared constants and helpers for the interrupt crossing sink.
package int_xing_pkg;

  localparam bit INT_MODE_LEVEL = 1'b0;
  localparam bit INT_MODE_EDGE  = 1'b1;

  localparam int MAX_INT    = 64;
  localparam int MAX_SYNC   = 8;
  localparam int MAX_FILTER = 255;

  // Counter must hold 0..FILTER_LEN-1; never narrower than one bit.
  function automatic int filter_cnt_w(input int filter_len);
    int w;
    w = $clog2(filter_len + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/int_xing_chan.sv
// One interrupt channel: resynchroniser, optional glitch filter, and
// either a level output or a sticky rising-edge pending bit.
module int_xing_chan
  import int_xing_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int FILTER_LEN  = 0,
  parameter bit EDGE        = INT_MODE_LEVEL
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  input  logic i_clr,
  output logic o_out
);

  logic w_s;
  logic w_f;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = i_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, so the chain really is SYNC_STAGES flops deep.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sync <= '0;
        else       r_sync <= (r_sync << 1) | SYNC_STAGES'(i_in);
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end

    if (FILTER_LEN == 0) begin : g_nofilt
      assign w_f = w_s;
    end else begin : g_filt
      localparam int CNT_W = filter_cnt_w(FILTER_LEN);
      logic             r_f;
      logic [CNT_W-1:0] r_cnt;
      // Any return of s to f restarts the count, so short pulses are dropped.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_f   <= 1'b0;
          r_cnt <= '0;
        end else if (w_s == r_f) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
          r_f   <= w_s;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      assign w_f = r_f;
    end

    if (EDGE == INT_MODE_EDGE) begin : g_edge
      logic r_prev;
      logic r_pend;
      logic w_rise;
      assign w_rise = w_f & ~r_prev;
      // A rise on the same edge as a clear wins: the set term is OR'd last.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_prev <= 1'b0;
          r_pend <= 1'b0;
        end else begin
          r_prev <= w_f;
          r_pend <= w_rise | (r_pend & ~i_clr);
        end
      end
      assign o_out = r_pend;
    end else begin : g_level
      logic w_unused_clr;
      assign w_unused_clr = i_clr;
      assign o_out        = w_f;
    end
  endgenerate

endmodule

// File: rtl/int_sync_crossing_sink_n.sv
// Receive side of an interrupt crossing: NUM_INT independent channels
// plus a combinational any-pending summary.
module int_sync_crossing_sink_n
  import int_xing_pkg::*;
#(
  parameter int                 NUM_INT     = 2,
  parameter int                 SYNC_STAGES = 3,
  parameter int                 FILTER_LEN  = 0,
  parameter logic [NUM_INT-1:0] EDGE_MASK   = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_INT-1:0] auto_in_sync,
  input  logic [NUM_INT-1:0] auto_clr,
  output logic [NUM_INT-1:0] auto_out,
  output logic               auto_pending_any
);

  generate
    if (NUM_INT < 1 || NUM_INT > MAX_INT) begin : g_bad_num_int
      $fatal(1, "NUM_INT out of range 1..64");
    end
    if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC) begin : g_bad_sync
      $fatal(1, "SYNC_STAGES out of range 0..8");
    end
    if (FILTER_LEN < 0 || FILTER_LEN > MAX_FILTER) begin : g_bad_filter
      $fatal(1, "FILTER_LEN out of range 0..255");
    end

    for (genvar i = 0; i < NUM_INT; i++) begin : g_chan
      int_xing_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .EDGE        (EDGE_MASK[i])
      ) u_chan (
        .i_clk (clock),
        .i_rst (reset),
        .i_in  (auto_in_sync[i]),
        .i_clr (auto_clr[i]),
        .o_out (auto_out[i])
      );
    end
  endgenerate

  assign auto_pending_any = |auto_out;

endmodule

// File: tb/tb_int_sync_crossing_sink_n.sv
// Directed bench for the interrupt crossing sink across several
// configurations, plus a mixed-mode run against a behavioural model.
module tb_int_sync_crossing_sink_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_err    = 0;
  int n_checks = 0;

  // A: pure passthrough
  logic [1:0] a_in = '0, a_clr = '0, a_out;
  logic       a_any;
  // B: 3-stage sync, level
  logic [1:0] b_in = '0, b_clr = '0, b_out;
  logic       b_any;
  // C: 2-stage sync, 4-cycle filter, level
  logic [1:0] c_in = '0, c_clr = '0, c_out;
  logic       c_any;
  // D: 2-stage sync, channel 0 edge, channel 1 level
  logic [1:0] d_in = '0, d_clr = '0, d_out;
  logic       d_any;
  // E: 8 channels, 1-stage sync, 2-cycle filter, mixed modes
  logic [7:0] e_in = '0, e_clr = '0, e_out;
  logic       e_any;

  int_sync_crossing_sink_n #(.NUM_INT(2), .SYNC_STAGES(0), .FILTER_LEN(0), .EDGE_MASK(2'b00)) u_a (
    .clock(clk), .reset(rst), .auto_in_sync(a_in), .auto_clr(a_clr),
    .auto_out(a_out), .auto_pending_any(a_any));
  int_sync_crossing_sink_n #(.NUM_INT(2), .SYNC_STAGES(3), .FILTER_LEN(0), .EDGE_MASK(2'b00)) u_b (
    .clock(clk), .reset(rst), .auto_in_sync(b_in), .auto_clr(b_clr),
    .auto_out(b_out), .auto_pending_any(b_any));
  int_sync_crossing_sink_n #(.NUM_INT(2), .SYNC_STAGES(2), .FILTER_LEN(4), .EDGE_MASK(2'b00)) u_c (
    .clock(clk), .reset(rst), .auto_in_sync(c_in), .auto_clr(c_clr),
    .auto_out(c_out), .auto_pending_any(c_any));
  int_sync_crossing_sink_n #(.NUM_INT(2), .SYNC_STAGES(2), .FILTER_LEN(0), .EDGE_MASK(2'b01)) u_d (
    .clock(clk), .reset(rst), .auto_in_sync(d_in), .auto_clr(d_clr),
    .auto_out(d_out), .auto_pending_any(d_any));
  int_sync_crossing_sink_n #(.NUM_INT(8), .SYNC_STAGES(1), .FILTER_LEN(2), .EDGE_MASK(8'hA5)) u_e (
    .clock(clk), .reset(rst), .auto_in_sync(e_in), .auto_clr(e_clr),
    .auto_out(e_out), .auto_pending_any(e_any));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model state for configuration E
  logic [7:0] e_mask = 8'hA5;
  logic [7:0] m_s, m_f, m_p, m_pend, m_exp;
  int         m_cnt [8];
  logic       f_old, s_old;

  initial begin
    // ---------------- reset state ----------------
    tick(2);
    check("rst_b_out", 16'(b_out), 16'h0);
    check("rst_c_out", 16'(c_out), 16'h0);
    check("rst_d_out", 16'({d_any, d_out}), 16'h0);
    check("rst_e_out", 16'({e_any, e_out}), 16'h0);
    rst = 1'b0;

    // ---------------- A: combinational passthrough ----------------
    a_in = 2'b10; #1;
    check("pass_out", 16'(a_out), 16'h2);
    check("pass_any", 16'(a_any), 16'h1);
    rst = 1'b1; #1;
    check("pass_in_reset", 16'(a_out), 16'h2);
    rst = 1'b0;
    a_in = 2'b00; #1;
    check("pass_any_low", 16'(a_any), 16'h0);
    a_in = 2'b01; #1;
    check("pass_out_01", 16'({a_any, a_out}), 16'h5);

    // ---------------- B: 3-stage level latency and mid-run reset ----------------
    tick(1);
    b_in = 2'b01;
    tick(2);
    check("sync3_before", 16'(b_out), 16'h0);
    tick(1);
    check("sync3_rise", 16'({b_any, b_out}), 16'h5);
    rst = 1'b1; #1;
    check("sync3_async_rst", 16'({b_any, b_out}), 16'h0);
    tick(1);
    check("sync3_hold_rst", 16'(b_out), 16'h0);
    rst = 1'b0;
    tick(2);
    check("sync3_reload_2", 16'(b_out), 16'h0);
    tick(1);
    check("sync3_reload_3", 16'(b_out), 16'h1);
    b_in = 2'b00;

    // ---------------- C: glitch filter ----------------
    c_in = 2'b01;
    tick(3);
    c_in = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("filt_short_drop", 16'({c_any, c_out}), 16'h0);
    end
    c_in = 2'b01;
    tick(4);
    c_in = 2'b00;
    tick(1);
    check("filt_rise_5", 16'(c_out), 16'h0);
    tick(1);
    check("filt_rise_6", 16'({c_any, c_out}), 16'h5);
    tick(3);
    check("filt_fall_5", 16'(c_out), 16'h1);
    tick(1);
    check("filt_fall_6", 16'(c_out), 16'h0);

    // ---------------- D: edge channel ----------------
    d_in = 2'b11;
    tick(2);
    check("edge_lvl_first", 16'(d_out), 16'h2);
    tick(1);
    check("edge_set", 16'(d_out), 16'h3);
    tick(3);
    check("edge_sticky", 16'(d_out), 16'h3);
    d_clr = 2'b01;
    tick(1);
    d_clr = 2'b00;
    check("edge_clear", 16'(d_out), 16'h2);
    tick(3);
    check("edge_one_set_per_high", 16'(d_out), 16'h2);
    d_clr = 2'b10;
    tick(1);
    d_clr = 2'b00;
    check("level_ignores_clr", 16'(d_out), 16'h2);

    d_in = 2'b00;
    tick(3);
    check("edge_low_idle", 16'({d_any, d_out}), 16'h0);
    d_in = 2'b01;
    tick(2);
    check("edge_pre_rise", 16'(d_out), 16'h0);
    d_clr = 2'b01;
    tick(1);
    d_clr = 2'b00;
    check("edge_set_wins", 16'({d_any, d_out}), 16'h5);
    tick(1);
    check("edge_set_holds", 16'(d_out), 16'h1);
    d_clr = 2'b01;
    tick(1);
    d_clr = 2'b00;
    check("edge_clear2", 16'(d_out), 16'h0);
    d_clr = 2'b01;
    tick(1);
    d_clr = 2'b00;
    check("edge_clear_noop", 16'(d_out), 16'h0);

    d_clr = 2'b01;
    d_in  = 2'b00;
    tick(3);
    check("edge_clrhold_idle", 16'(d_out), 16'h0);
    d_in = 2'b01;
    tick(2);
    check("edge_clrhold_pre", 16'(d_out), 16'h0);
    tick(1);
    check("edge_clrhold_pulse", 16'(d_out), 16'h1);
    tick(1);
    check("edge_clrhold_drop", 16'(d_out), 16'h0);
    d_clr = 2'b00;
    d_in  = 2'b00;

    // ---------------- E: mixed modes vs. model ----------------
    e_in  = '0;
    e_clr = '0;
    rst   = 1'b1;
    tick(1);
    rst   = 1'b0;
    m_s = '0; m_f = '0; m_p = '0; m_pend = '0;
    for (int ch = 0; ch < 8; ch++) m_cnt[ch] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      e_in  = e_in ^ (8'($urandom) & 8'($urandom));
      e_clr = 8'($urandom) & 8'($urandom);
      tick(1);
      for (int ch = 0; ch < 8; ch++) begin
        f_old = m_f[ch];
        s_old = m_s[ch];
        m_pend[ch] = (f_old & ~m_p[ch]) | (m_pend[ch] & ~e_clr[ch]);
        m_p[ch]    = f_old;
        if (s_old == f_old) begin
          m_cnt[ch] = 0;
        end else if (m_cnt[ch] == 1) begin
          m_f[ch]   = s_old;
          m_cnt[ch] = 0;
        end else begin
          m_cnt[ch] = m_cnt[ch] + 1;
        end
        m_s[ch]   = e_in[ch];
        m_exp[ch] = e_mask[ch] ? m_pend[ch] : m_f[ch];
      end
      check("mixed_model", 16'({e_any, e_out}), 16'({|m_exp, m_exp}));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
